a2d_spi_slave: RTL and testbench

- Synthesizable SPI responder that models the 8-channel, 12-bit A2D converter on the far end of the line follower's A2D SPI link.
- Decodes the channel address sent on MOSI and returns that channel's 12-bit sample on MISO.
- Per-channel sample values are held in an internal register file, loaded through a simple write port; the testbench or a sensor model drives that port.
- Shares one clock with the SPI master. SS_n, SCLK and MOSI are still treated as asynchronous inputs and synchronized before use.

---
 rtl/a2d_pkg.sv | 24 ++
 rtl/a2d_spi_slave_if.sv | 23 ++
 rtl/a2d_spi_slave_spi_sync_edge.sv | 32 +++
 rtl/a2d_spi_slave.sv | 161 ++++++++++++++++
 tb/tb_a2d_spi_slave.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI responder.
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RESP    = 2'd2,
        OVERRUN = 2'd3
    } a2d_slv_state_t;

    localparam int CMD_BITS  = 16;
    localparam int RESP_BITS = 16;
    localparam int CHNL_MSB  = 13;
    localparam int CHNL_LSB  = 11;
    localparam int DATA_W    = 12;
    localparam int NUM_CHNL  = 8;
    localparam int CNT_W     = 6;

    // Saturating increment: the edge counter sticks at its maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/a2d_spi_slave_if.sv
// SPI link plus channel-register write port, seen from master and slave sides.
interface a2d_spi_slave_if;
    import a2d_pkg::*;

    logic              a2d_SS_n;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic              wr_en;
    logic [2:0]        wr_chnnl;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output a2d_SS_n, SCLK, MOSI, wr_en, wr_chnnl, wr_data,
        input  MISO
    );

    modport slave (
        input  a2d_SS_n, SCLK, MOSI, wr_en, wr_chnnl, wr_data,
        output MISO
    );

endinterface

// File: rtl/a2d_spi_slave_spi_sync_edge.sv
// Two-flop synchronizer with rise/fall detection on the synchronized copy.
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one history flop; resets to the idle-high bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/a2d_spi_slave.sv
// SPI responder modelling an 8-channel 12-bit A2D: decodes the channel from
// the command word and shifts that channel's sample back on MISO.
module a2d_spi_slave
    import a2d_pkg::*;
#(
    parameter int                FRAME_BITS = 32,
    parameter logic [DATA_W-1:0] RST_VAL    = 12'h800
) (
    input  logic        clk,
    input  logic        rst_n,
    a2d_spi_slave_if.slave spi,
    output logic [2:0]  last_chnnl,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [CNT_W-1:0] RESP_START = CNT_W'(CMD_BITS + 1);
    localparam logic [CNT_W-1:0] FRAME_END  = CNT_W'(FRAME_BITS);

    logic w_ss_sync, w_ss_rise, w_ss_fall;
    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_mosi_sync, w_mosi_rise, w_mosi_fall;

    spi_sync_edge u_sync_ss (
        .clk(clk), .rst_n(rst_n), .i_async(spi.a2d_SS_n),
        .o_sync(w_ss_sync), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_sync_edge u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(spi.SCLK),
        .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    // MOSI only needs the synchronized level; its edge outputs are not used.
    spi_sync_edge u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_async(spi.MOSI),
        .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    // Channel register file: one independently written register per channel.
    logic [NUM_CHNL-1:0][DATA_W-1:0] w_chan;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHNL; gi++) begin : g_chan
            logic [DATA_W-1:0] r_val;
            // Load the sample when the write port targets this channel.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_val <= RST_VAL;
                end else if (spi.wr_en && (spi.wr_chnnl == 3'(gi))) begin
                    r_val <= spi.wr_data;
                end
            end
            assign w_chan[gi] = r_val;
        end
    endgenerate

    a2d_slv_state_t         r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CMD_BITS-1:0]    r_cmd;
    logic [RESP_BITS-1:0]   r_shift;
    logic                   r_miso;
    logic [2:0]             r_last_chnnl;
    logic                   r_frame_done;
    logic                   r_frame_err;

    logic [CNT_W-1:0]       w_cnt_inc;
    logic [RESP_BITS-1:0]   w_snap;

    assign w_cnt_inc = sat_inc(r_cnt);
    // Response word is the zero-padded sample of the channel decoded so far.
    assign w_snap    = {{(RESP_BITS-DATA_W){1'b0}}, w_chan[r_cmd[CHNL_MSB:CHNL_LSB]]};

    // Frame FSM: counts SCLK falls, captures the command, shifts the snapshot out
    // and classifies the frame when SS_n rises (which overrides any same-clk SCLK edge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cmd        <= '0;
            r_shift      <= '0;
            r_miso       <= 1'b0;
            r_last_chnnl <= 3'd0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if ((r_state != IDLE) && w_ss_rise) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_miso  <= 1'b0;
                if (r_cnt == FRAME_END) begin
                    r_frame_done <= 1'b1;
                    r_last_chnnl <= r_cmd[CHNL_MSB:CHNL_LSB];
                end else begin
                    r_frame_err  <= 1'b1;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt  <= '0;
                        r_miso <= 1'b0;
                        if (w_ss_fall) begin
                            r_state <= CMD;
                            r_cmd   <= '0;
                        end
                    end
                    CMD: begin
                        if (w_sclk_rise) begin
                            r_cmd <= {r_cmd[CMD_BITS-2:0], w_mosi_sync};
                        end
                        if (w_sclk_fall) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == RESP_START) begin
                                // Snapshot taken here; later writes do not disturb this frame.
                                r_state <= RESP;
                                r_miso  <= w_snap[RESP_BITS-1];
                                r_shift <= {w_snap[RESP_BITS-2:0], 1'b0};
                            end else begin
                                r_miso  <= 1'b0;
                            end
                        end
                    end
                    RESP: begin
                        if (w_sclk_fall) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc > FRAME_END) begin
                                r_state <= OVERRUN;
                                r_miso  <= 1'b0;
                            end else begin
                                r_miso  <= r_shift[RESP_BITS-1];
                                r_shift <= {r_shift[RESP_BITS-2:0], 1'b0};
                            end
                        end
                    end
                    OVERRUN: begin
                        if (w_sclk_fall) begin
                            r_cnt  <= w_cnt_inc;
                        end
                        r_miso <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_miso  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi.MISO   = r_miso;
    assign last_chnnl = r_last_chnnl;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

    // Levels and edges that the frame logic does not consume.
    logic w_unused;
    assign w_unused = ^{w_ss_sync, w_sclk_sync, w_mosi_rise, w_mosi_fall, r_cmd[CMD_BITS-1]};

endmodule

// File: tb/tb_a2d_spi_slave.sv
// Directed bench: a bus-functional SPI master runs frames, expected results are
// queued per frame and a separate monitor compares them as frames complete.
module tb_a2d_spi_slave;
    import a2d_pkg::*;

    localparam int HALF = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] last_chnnl;
    logic       frame_done;
    logic       frame_err;

    a2d_spi_slave_if bus();

    a2d_spi_slave #(.FRAME_BITS(32), .RST_VAL(12'h800)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .spi(bus.slave),
        .last_chnnl(last_chnnl),
        .frame_done(frame_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] res;
        bit          chk_res;
        logic [2:0]  chn;
        logic        err;
        int          done_tot;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] model[8];
    int          exp_done = 0;
    logic [2:0]  exp_last = 3'd0;
    logic        exp_err = 1'b0;
    int          done_cnt = 0;
    int          txn = 0;

    logic [11:0] obs_res = '0;
    int          obs_bad = 0;
    bit          obs_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Count frame_done pulses; a pulse wider than one clk counts more than once.
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    // Monitor: compares each completed frame against the head of the expectation queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (obs_valid) begin
                txn++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(txn), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %0d: res=%03h exp=%03h chk=%0d last=%0d err=%b done=%0d",
                             txn, obs_res, e.res, e.chk_res, last_chnnl, frame_err, done_cnt);
                    if (e.chk_res) chk("res", 32'(obs_res), 32'(e.res));
                    chk("miso_zero_bits", 32'(obs_bad), 32'(0));
                    chk("last_chnnl", 32'(last_chnnl), 32'(e.chn));
                    chk("frame_err", 32'(frame_err), 32'(e.err));
                    chk("done_count", 32'(done_cnt), 32'(e.done_tot));
                end
            end
        end
    end

    task automatic wr(input int ch, input logic [11:0] d);
        @(negedge clk);
        bus.wr_en    = 1'b1;
        bus.wr_chnnl = ch[2:0];
        bus.wr_data  = d;
        @(negedge clk);
        bus.wr_en    = 1'b0;
        model[ch]    = d;
    endtask

    // Master frame: nper SCLK periods, optional register write during period wr_p.
    task automatic run_frame(input logic [2:0] ch, input int nper, input int wr_p,
                             input int wr_ch, input logic [11:0] wr_d);
        logic [15:0] cmd;
        logic [15:0] w;
        int          bad;
        cmd = {2'b00, ch, 11'h000};
        w   = '0;
        bad = 0;
        @(negedge clk);
        bus.a2d_SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int p = 1; p <= nper; p++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = (p <= 16) ? cmd[16-p] : 1'b0;
            if (p == wr_p) begin
                repeat (6) @(negedge clk);
                wr(wr_ch, wr_d);
                repeat (HALF - 8) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            bus.SCLK = 1'b1;
            if (p >= 17 && p <= 32) w = {w[14:0], bus.MISO};
            else if (bus.MISO !== 1'b0) bad++;
            repeat (HALF) @(negedge clk);
        end
        if (nper >= 32 && w[15:12] != 4'h0) bad++;
        repeat (4) @(negedge clk);
        bus.a2d_SS_n = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        obs_res   = w[11:0];
        obs_bad   = bad;
        obs_valid = 1'b1;
        @(posedge clk);
        obs_valid = 1'b0;
    endtask

    task automatic full_frame(input logic [2:0] ch, input int wr_p, input int wr_ch, input logic [11:0] wr_d);
        exp_t e;
        exp_done++;
        exp_last   = ch;
        e.res      = model[ch];
        e.chk_res  = 1'b1;
        e.chn      = exp_last;
        e.err      = exp_err;
        e.done_tot = exp_done;
        exp_q.push_back(e);
        run_frame(ch, 32, wr_p, wr_ch, wr_d);
    endtask

    task automatic bad_frame(input logic [2:0] ch, input int nper);
        exp_t e;
        exp_err    = 1'b1;
        e.res      = model[ch];
        e.chk_res  = (nper >= 32);
        e.chn      = exp_last;
        e.err      = 1'b1;
        e.done_tot = exp_done;
        exp_q.push_back(e);
        run_frame(ch, nper, 0, 0, 12'h000);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        logic [15:0] cmd;
        bus.a2d_SS_n = 1'b1;
        bus.SCLK     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_chnnl = 3'd0;
        bus.wr_data  = 12'h000;
        for (int i = 0; i < 8; i++) model[i] = 12'h800;

        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(bus.MISO), 32'(0));
        chk("rst_last_chnnl", 32'(last_chnnl), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));
        chk("rst_frame_err", 32'(frame_err), 32'(0));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reset contents, then a written channel.
        full_frame(3'd0, 0, 0, 12'h000);
        wr(5, 12'hA5C);
        full_frame(3'd5, 0, 0, 12'h000);

        // Back-to-back frames across all channels.
        for (int c = 0; c < 8; c++) wr(c, 12'(12'h100 * c + c));
        for (int c = 0; c < 8; c++) full_frame(3'(c), 0, 0, 12'h000);

        // Write during period 20 must not disturb the snapshot.
        wr(2, 12'h123);
        full_frame(3'd2, 20, 2, 12'hFFF);
        full_frame(3'd2, 0, 0, 12'h000);

        // Short frame, then a normal one.
        bad_frame(3'd3, 10);
        full_frame(3'd6, 0, 0, 12'h000);

        // Reset during period 18.
        cmd = {2'b00, 3'd1, 11'h000};
        @(negedge clk);
        bus.a2d_SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int p = 1; p <= 17; p++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = (p <= 16) ? cmd[16-p] : 1'b0;
            repeat (HALF) @(negedge clk);
            bus.SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        bus.SCLK = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("miso_in_reset", 32'(bus.MISO), 32'(0));
        bus.a2d_SS_n = 1'b1;
        bus.SCLK     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst2_frame_err", 32'(frame_err), 32'(0));
        chk("rst2_last_chnnl", 32'(last_chnnl), 32'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 12'h800;
        exp_last = 3'd0;
        exp_err  = 1'b0;
        repeat (4) @(negedge clk);

        // Every register back at its reset value.
        for (int c = 0; c < 8; c++) full_frame(3'(c), 0, 0, 12'h000);

        // Frame running past 32 periods.
        bad_frame(3'd4, 34);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
